if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline; producer of the `addr`/`inst_i` pair consumed by ID.
- Owns the PC and drives a req/ack instruction-memory port.
- Registers the fetched instruction into the IF/ID boundary.
- Honours the pipeline stall from ctrl and the branch/jump redirect (`branch_flag`, `branch_target_address`) that ID returns.
- No delay slot: a taken redirect flushes the sequentially fetched instruction.

---
 rtl/if_stage_pkg.sv | 8 +
 rtl/if_stage_if.sv | 10 +
 rtl/if_skid_buf.sv | 29 ++
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, bubble encoding, reset PC and fetch FSM states
package if_stage_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] DEF_NOP_INST = 32'h0000_0013;
    localparam logic [ADDR_WIDTH-1:0] DEF_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: req/ack instruction-memory port between the fetch stage and memory
interface if_stage_if;
    import if_stage_pkg::*;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [INST_WIDTH-1:0] mem_rdata;
    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry {addr, inst} park slot for a word fetched while ID is stalled
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  drain,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [INST_WIDTH-1:0] d_inst,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  full
);
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr <= '0;
            inst <= '0;
            full <= 1'b0;
        end else begin
            if (load) begin
                addr <= d_addr;
                inst <= d_inst;
            end
            full <= load ? 1'b1 : (drain || clear) ? 1'b0 : full;
        end
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage owning the PC, the memory request and the IF/ID registers
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [INST_WIDTH-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  stall,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_target_address,
    if_stage_if.master            mem,
    output logic [ADDR_WIDTH-1:0] id_addr,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic                  id_valid
);
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n, addr_q, addr_n, id_addr_n, buf_addr;
    logic [INST_WIDTH-1:0] id_inst_n, buf_inst;
    logic kill, kill_n, id_valid_n, buf_load, buf_drain, buf_clear, buf_full, redirect;

    assign mem.mem_req  = state == S_REQ;
    assign mem.mem_addr = addr_q;
    assign redirect     = !stall && branch_flag;

    if_skid_buf u_buf (
        .CLK    (CLK),
        .RST    (RST),
        .load   (buf_load),
        .drain  (buf_drain),
        .clear  (buf_clear),
        .d_addr (addr_q),
        .d_inst (mem.mem_rdata),
        .addr   (buf_addr),
        .inst   (buf_inst),
        .full   (buf_full)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            addr_q   <= '0;
            kill     <= 1'b0;
            id_addr  <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            addr_q   <= addr_n;
            kill     <= kill_n;
            id_addr  <= id_addr_n;
            id_inst  <= id_inst_n;
            id_valid <= id_valid_n;
        end
    end

    // Without a stall ID sees a bubble unless a word is delivered this cycle
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        addr_n     = addr_q;
        kill_n     = kill;
        id_addr_n  = id_addr;
        id_inst_n  = stall ? id_inst : NOP_INST;
        id_valid_n = stall ? id_valid : 1'b0;
        buf_load   = 1'b0;
        buf_drain  = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            S_IDLE: begin
                state_n   = S_REQ;
                pc_n      = redirect ? branch_target_address : pc;
                addr_n    = pc_n;
                buf_clear = redirect;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_n      = branch_target_address;
                    buf_clear = 1'b1;
                    kill_n    = !mem.mem_ack;
                    addr_n    = mem.mem_ack ? branch_target_address : addr_q;
                end else if (mem.mem_ack && kill) begin
                    kill_n = 1'b0;
                    addr_n = pc;
                end else if (mem.mem_ack) begin
                    pc_n     = pc + 32'd4;
                    addr_n   = pc + 32'd4;
                    buf_load = stall;
                    state_n  = stall ? S_HOLD : S_REQ;
                    if (!stall) begin
                        id_addr_n  = addr_q;
                        id_inst_n  = mem.mem_rdata;
                        id_valid_n = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_n = S_REQ;
                    if (branch_flag) begin
                        pc_n      = branch_target_address;
                        addr_n    = branch_target_address;
                        buf_clear = 1'b1;
                    end else begin
                        id_addr_n  = buf_addr;
                        id_inst_n  = buf_inst;
                        id_valid_n = buf_full;
                        buf_drain  = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus random stall/redirect/ack traffic checked against a transaction-level model
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK, RST, stall, branch_flag, ack;
    logic [31:0] tgt, id_addr, id_inst;
    logic id_valid;
    int checks, errors;

    if_stage_if mem ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    assign mem.mem_ack   = ack;
    assign mem.mem_rdata = mem_word(mem.mem_addr);

    if_stage dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .stall                 (stall),
        .branch_flag           (branch_flag),
        .branch_target_address (tgt),
        .mem                   (mem),
        .id_addr               (id_addr),
        .id_inst               (id_inst),
        .id_valid              (id_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: a fetch pointer, one outstanding request (possibly doomed), and a queue of parked words
    logic [31:0] m_pc, m_raddr, m_id_addr, m_id_inst;
    logic m_req, m_fresh, m_doomed, m_id_valid;
    logic [63:0] parked[$];

    task automatic model(input logic r, s, br, input logic [31:0] t, input logic a);
        logic [63:0] w;
        logic [31:0] word;
        if (r) begin
            m_pc = 32'h0; m_raddr = 32'h0; m_req = 1'b0; m_fresh = 1'b1; m_doomed = 1'b0;
            parked.delete();
            m_id_addr = 32'h0; m_id_inst = NOP; m_id_valid = 1'b0;
            return;
        end
        if (!s) begin
            m_id_inst = NOP;
            m_id_valid = 1'b0;
        end
        if (m_fresh) begin
            m_fresh = 1'b0;
            m_req = 1'b1;
            if (!s && br) m_pc = t;
            m_raddr = m_pc;
        end else if (parked.size() != 0) begin
            if (!s) begin
                w = parked.pop_front();
                m_req = 1'b1;
                if (br) begin
                    m_pc = t;
                    m_raddr = t;
                end else begin
                    m_id_addr = w[63:32];
                    m_id_inst = w[31:0];
                    m_id_valid = 1'b1;
                end
            end
        end else if (!s && br) begin
            m_pc = t;
            m_doomed = !a;
            if (a) m_raddr = t;
        end else if (a) begin
            if (m_doomed) begin
                m_doomed = 1'b0;
                m_raddr = m_pc;
            end else begin
                word = mem_word(m_raddr);
                if (s) begin
                    parked.push_back({m_raddr, word});
                    m_req = 1'b0;
                end else begin
                    m_id_addr = m_raddr;
                    m_id_inst = word;
                    m_id_valid = 1'b1;
                end
                m_pc = m_pc + 32'd4;
                m_raddr = m_pc;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, s, br, input logic [31:0] t, input logic a);
        RST = r; stall = s; branch_flag = br; tgt = t; ack = a;
        @(posedge CLK);
        #1;
        model(r, s, br, t, a);
        chk("mem_req", {31'h0, mem.mem_req}, {31'h0, m_req});
        chk("mem_addr", mem.mem_addr, m_raddr);
        chk("id_addr", id_addr, m_id_addr);
        chk("id_inst", id_inst, m_id_inst);
        chk("id_valid", {31'h0, id_valid}, {31'h0, m_id_valid});
    endtask

    task automatic go(input logic s, br, input logic [31:0] t, input logic a);
        step(1'b0, s, br, t, a);
    endtask

    task automatic rst_cycle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic s, br, a, r;
        logic [31:0] t;
        checks = 0; errors = 0;
        RST = 1'b1; stall = 1'b0; branch_flag = 1'b0; tgt = '0; ack = 1'b0;
        rst_cycle();
        rst_cycle();
        chk("reset_inst", id_inst, NOP);
        // zero-wait memory: first valid two cycles after reset
        go(0, 0, 0, 1);
        chk("lat1_valid", {31'h0, id_valid}, 32'h0);
        go(0, 0, 0, 1);
        chk("lat2_valid", {31'h0, id_valid}, 32'h1);
        chk("lat2_addr", id_addr, 32'h0);
        go(0, 0, 0, 1);
        go(0, 0, 0, 1);
        go(0, 0, 0, 1);
        chk("seq_addr", id_addr, 32'hC);
        // stall while 0x10 is acked
        go(1, 0, 0, 1);
        go(1, 0, 0, 0);
        go(1, 0, 0, 0);
        chk("stall_hold", id_addr, 32'hC);
        go(0, 0, 0, 0);
        chk("drain_addr", id_addr, 32'h10);
        chk("after_drain_fetch", mem.mem_addr, 32'h14);
        go(0, 0, 0, 1);
        // redirect with a slow memory and 0x08 outstanding
        rst_cycle();
        go(0, 0, 0, 0);
        go(0, 0, 0, 1);
        go(0, 0, 0, 1);
        go(0, 0, 0, 0);
        go(0, 1, 32'h100, 0);
        chk("kill_addr_stable", mem.mem_addr, 32'h8);
        go(0, 0, 0, 0);
        go(0, 0, 0, 1);
        chk("killed_target", mem.mem_addr, 32'h100);
        go(0, 0, 0, 0);
        go(0, 0, 0, 0);
        go(0, 0, 0, 1);
        chk("target_delivered", id_addr, 32'h100);
        // redirect coinciding with the ack for 0x0C
        rst_cycle();
        go(0, 0, 0, 0);
        go(0, 0, 0, 1);
        go(0, 0, 0, 1);
        go(0, 0, 0, 1);
        go(0, 1, 32'h200, 1);
        chk("same_cycle_target", mem.mem_addr, 32'h200);
        chk("same_cycle_no_valid", {31'h0, id_valid}, 32'h0);
        go(0, 0, 0, 1);
        // branch ignored under stall, taken when the stall drops
        go(1, 0, 0, 1);
        go(1, 1, 32'h300, 0);
        chk("stall_ignores_branch", id_addr, 32'h200);
        go(0, 1, 32'h300, 0);
        chk("hold_redirect", mem.mem_addr, 32'h300);
        go(0, 0, 0, 1);
        // reset mid-fetch, ack in the following cycle ignored
        go(0, 0, 0, 0);
        rst_cycle();
        go(0, 0, 0, 1);
        chk("post_reset_fetch", mem.mem_addr, 32'h0);
        go(0, 0, 0, 1);
        // pc wrap and unaligned target
        go(0, 1, 32'hFFFF_FFFC, 1);
        go(0, 0, 0, 1);
        chk("wrap_addr", mem.mem_addr, 32'h0);
        go(0, 0, 0, 1);
        go(0, 1, 32'h0000_0103, 1);
        go(0, 0, 0, 1);
        chk("unaligned_next", mem.mem_addr, 32'h107);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 199) == 0;
            s  = $urandom_range(0, 3) == 0;
            br = $urandom_range(0, 9) == 0;
            t  = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
            a  = m_req && ($urandom_range(0, 1) == 1);
            step(r, s, br, t, a);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
